// File: rtl/cmd_sched_pkg.sv
// Shared definitions for the command scheduler: FSM states, op codes,
// command word indices, engine indices and DMA read-port masks.
package cmd_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DISPATCH = 3'd2,
        S_WAIT     = 3'd3,
        S_DONE     = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    localparam logic [2:0] OP_CONV1X1 = 3'd1;
    localparam logic [2:0] OP_CONV3X3 = 3'd2;
    localparam logic [2:0] OP_CONVDW  = 3'd3;
    localparam logic [2:0] OP_MAXPOOL = 3'd4;
    localparam logic [2:0] OP_AVEPOOL = 3'd5;

    localparam logic [7:0] W_OP     = 8'd0;
    localparam logic [7:0] W_CH     = 8'd1;
    localparam logic [7:0] W_NUM    = 8'd2;
    localparam logic [7:0] W_WADDR  = 8'd3;
    localparam logic [7:0] W_DADDR  = 8'd4;
    localparam logic [7:0] W_WBADDR = 8'd5;

    localparam int ENG_CONV    = 0;
    localparam int ENG_MAXPOOL = 1;
    localparam int ENG_AVEPOOL = 2;

    localparam logic [3:0] MASK_HI  = 4'b1100;
    localparam logic [3:0] MASK_LO  = 4'b0011;
    localparam logic [3:0] MASK_ALL = 4'b1111;

endpackage

// File: rtl/cmd_sched_if.sv
// Command word stream between the command FIFO (master) and the scheduler (slave).
interface cmd_sched_if;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;

    modport master (output cmd_data, output cmd_valid, input cmd_ready);
    modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/cmd_sched_decode.sv
// Combinational decode of a fetched command into engine select, DMA port mask
// and an error flag for unsupported op codes or bad output-channel counts.
module cmd_sched_decode
    import cmd_sched_pkg::*;
#(
    parameter int N_ENG  = 3,
    parameter int N_PORT = 4,
    parameter int PAR_N  = 16
) (
    input  logic [2:0]        op_type,
    input  logic [15:0]       o_ch,
    output logic [N_ENG-1:0]  eng_oh,
    output logic [N_PORT-1:0] port_mask,
    output logic              err
);

    always_comb begin
        eng_oh    = '0;
        port_mask = '0;
        err       = 1'b0;
        case (op_type)
            OP_CONV1X1: begin eng_oh[ENG_CONV]    = 1'b1; port_mask = N_PORT'(MASK_HI);  end
            OP_CONV3X3: begin eng_oh[ENG_CONV]    = 1'b1; port_mask = N_PORT'(MASK_LO);  end
            OP_CONVDW:  begin eng_oh[ENG_CONV]    = 1'b1; port_mask = N_PORT'(MASK_ALL); end
            OP_MAXPOOL: begin eng_oh[ENG_MAXPOOL] = 1'b1; port_mask = N_PORT'(MASK_LO);  end
            OP_AVEPOOL: begin eng_oh[ENG_AVEPOOL] = 1'b1; port_mask = N_PORT'(MASK_LO);  end
            default:    err = 1'b1;
        endcase
        // Completion is counted in PAR_N steps, so o_ch must be a nonzero multiple.
        if (o_ch == 16'd0 || (o_ch % 16'(PAR_N)) != 16'd0)
            err = 1'b1;
        if (err) begin
            eng_oh    = '0;
            port_mask = '0;
        end
    end

endmodule

// File: rtl/cmd_sched.sv
// Command scheduler: fetches CMD_WORDS-word commands, dispatches them to compute
// engines and tracks completion. Optional perf counters under CMD_SCHED_PERF_EN.
module cmd_sched
    import cmd_sched_pkg::*;
#(
    parameter int N_ENG     = 3,
    parameter int CMD_WORDS = 6,
    parameter int PAR_N     = 16,
    parameter int N_PORT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_en,
    input  logic [7:0]        cmd_count,
    cmd_sched_if.slave        cmd,
    output logic [N_ENG-1:0]  eng_start,
    input  logic [N_ENG-1:0]  eng_done,
    output logic [N_PORT-1:0] rd_port_en,
    output logic [2:0]        op_type,
    output logic [15:0]       i_ch,
    output logic [15:0]       o_ch,
    output logic [15:0]       op_num,
    output logic [31:0]       weight_addr,
    output logic [31:0]       data_addr,
    output logic [31:0]       wb_addr,
    output logic              busy,
    output logic              irq,
    input  logic              irq_clr,
    output logic              err
`ifdef CMD_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [15:0]       perf_layers
`endif
);

    state_t              state_q, state_d;
    logic [7:0]          widx_q, widx_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          layer_q, layer_d;
    logic [15:0]         ch_cnt_q, ch_cnt_d;
    logic [N_ENG-1:0]    eng_sel_q, eng_sel_d;
    logic [N_PORT-1:0]   rd_port_en_q, rd_port_en_d;
    logic [2:0]          op_type_q, op_type_d;
    logic [15:0]         i_ch_q, i_ch_d, o_ch_q, o_ch_d, op_num_q, op_num_d;
    logic [31:0]         weight_addr_q, weight_addr_d;
    logic [31:0]         data_addr_q, data_addr_d;
    logic [31:0]         wb_addr_q, wb_addr_d;

    logic [N_ENG-1:0]    dec_eng;
    logic [N_PORT-1:0]   dec_mask;
    logic                dec_err;
    logic                op_accept;
    logic                layer_done;

    cmd_sched_decode #(.N_ENG(N_ENG), .N_PORT(N_PORT), .PAR_N(PAR_N)) u_decode (
        .op_type   (op_type_q),
        .o_ch      (o_ch_q),
        .eng_oh    (dec_eng),
        .port_mask (dec_mask),
        .err       (dec_err)
    );

    assign op_accept  = (state_q == S_IDLE) && op_en;
    // Only the engine latched at dispatch may advance the channel count.
    assign layer_done = (state_q == S_WAIT) && (|(eng_done & eng_sel_q))
                        && ((ch_cnt_q + 16'(PAR_N)) == o_ch_q);

    always_comb begin
        state_d       = state_q;
        widx_d        = widx_q;
        cnt_d         = cnt_q;
        layer_d       = layer_q;
        ch_cnt_d      = ch_cnt_q;
        eng_sel_d     = eng_sel_q;
        rd_port_en_d  = rd_port_en_q;
        op_type_d     = op_type_q;
        i_ch_d        = i_ch_q;
        o_ch_d        = o_ch_q;
        op_num_d      = op_num_q;
        weight_addr_d = weight_addr_q;
        data_addr_d   = data_addr_q;
        wb_addr_d     = wb_addr_q;
        case (state_q)
            S_IDLE: begin
                if (op_en) begin
                    cnt_d   = cmd_count;
                    layer_d = 8'd0;
                    widx_d  = 8'd0;
                    state_d = (cmd_count != 8'd0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (cmd.cmd_valid) begin
                    case (widx_q)
                        W_OP:     op_type_d = cmd.cmd_data[2:0];
                        W_CH:     begin
                                      i_ch_d = cmd.cmd_data[15:0];
                                      o_ch_d = cmd.cmd_data[31:16];
                                  end
                        W_NUM:    op_num_d      = cmd.cmd_data[31:16];
                        W_WADDR:  weight_addr_d = cmd.cmd_data;
                        W_DADDR:  data_addr_d   = cmd.cmd_data;
                        W_WBADDR: wb_addr_d     = cmd.cmd_data;
                        default:  ;
                    endcase
                    if (widx_q == 8'(CMD_WORDS - 1)) begin
                        widx_d  = 8'd0;
                        state_d = S_DISPATCH;
                    end else begin
                        widx_d = widx_q + 8'd1;
                    end
                end
            end
            S_DISPATCH: begin
                ch_cnt_d = 16'd0;
                if (dec_err) begin
                    rd_port_en_d = '0;
                    state_d      = S_ERR;
                end else begin
                    eng_sel_d    = dec_eng;
                    rd_port_en_d = dec_mask;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (layer_done) begin
                    ch_cnt_d     = o_ch_q;
                    rd_port_en_d = '0;
                    layer_d      = layer_q + 8'd1;
                    state_d      = ((layer_q + 8'd1) == cnt_q) ? S_DONE : S_FETCH;
                end else if (|(eng_done & eng_sel_q)) begin
                    ch_cnt_d = ch_cnt_q + 16'(PAR_N);
                end
            end
            S_DONE, S_ERR: begin
                if (irq_clr)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            widx_q        <= 8'd0;
            cnt_q         <= 8'd0;
            layer_q       <= 8'd0;
            ch_cnt_q      <= 16'd0;
            eng_sel_q     <= '0;
            rd_port_en_q  <= '0;
            op_type_q     <= 3'd0;
            i_ch_q        <= 16'd0;
            o_ch_q        <= 16'd0;
            op_num_q      <= 16'd0;
            weight_addr_q <= 32'd0;
            data_addr_q   <= 32'd0;
            wb_addr_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            widx_q        <= widx_d;
            cnt_q         <= cnt_d;
            layer_q       <= layer_d;
            ch_cnt_q      <= ch_cnt_d;
            eng_sel_q     <= eng_sel_d;
            rd_port_en_q  <= rd_port_en_d;
            op_type_q     <= op_type_d;
            i_ch_q        <= i_ch_d;
            o_ch_q        <= o_ch_d;
            op_num_q      <= op_num_d;
            weight_addr_q <= weight_addr_d;
            data_addr_q   <= data_addr_d;
            wb_addr_q     <= wb_addr_d;
        end
    end

    assign cmd.cmd_ready = (state_q == S_FETCH);
    assign eng_start     = (state_q == S_DISPATCH && !dec_err) ? dec_eng : '0;
    assign rd_port_en    = rd_port_en_q;
    assign op_type       = op_type_q;
    assign i_ch          = i_ch_q;
    assign o_ch          = o_ch_q;
    assign op_num        = op_num_q;
    assign weight_addr   = weight_addr_q;
    assign data_addr     = data_addr_q;
    assign wb_addr       = wb_addr_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign irq           = (state_q == S_DONE) || (state_q == S_ERR);
    assign err           = (state_q == S_ERR);

`ifdef CMD_SCHED_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [15:0] perf_layers_q, perf_layers_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_layers_d = perf_layers_q;
        if (op_accept) begin
            perf_cycles_d = 32'd0;
            perf_layers_d = 16'd0;
        end else begin
            if (busy && perf_cycles_q != 32'hFFFF_FFFF)
                perf_cycles_d = perf_cycles_q + 32'd1;
            if (layer_done)
                perf_layers_d = perf_layers_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= 32'd0;
            perf_layers_q <= 16'd0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_layers_q <= perf_layers_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_layers = perf_layers_q;
`endif

endmodule
